// File: rtl/res_scoreboard.sv
// ---------------------------------------------------------------------------
// res_scoreboard
//
// In-order expected-vs-actual response checker. Expected responses are
// buffered in a DEPTH-entry FIFO; every actual response is compared against
// the oldest buffered expected response. Saturating pass/fail/orphan/overflow
// counters, a sticky mismatch flag and a snapshot of the first failing
// compare are kept until rst or clear.
//
// Optional feature macro: RES_SB_MASK_EN
//   defined   -> adds input cmp_mask; only bits set in the mask are compared
//   undefined -> every data bit is compared (default build)
//
// Ports:
//   clk, rst (async, active-high), clear (sync clear of all state)
//   exp_valid/exp_data   expected response stream
//   act_valid/act_data   actual response stream
//   cmp_mask             per-bit compare enable (RES_SB_MASK_EN only)
//   cmp_valid/cmp_pass   one-cycle compare result, one cycle after the event
//   pass_cnt, fail_cnt, orphan_cnt, ovf_cnt   saturating event counters
//   pending, fifo_full   expected-FIFO occupancy
//   mismatch             sticky fail/orphan flag
//   first_fail_idx/_exp/_act   snapshot of the first failing compare
//   state                0 IDLE, 1 RUN, 2 FAIL
// ---------------------------------------------------------------------------
module res_scoreboard #(
    parameter int DATA_WIDTH = 256,
    parameter int DEPTH      = 16,
    parameter int EDGE_MODE  = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       exp_valid,
    input  logic [DATA_WIDTH-1:0]      exp_data,
    input  logic                       act_valid,
    input  logic [DATA_WIDTH-1:0]      act_data,
`ifdef RES_SB_MASK_EN
    input  logic [DATA_WIDTH-1:0]      cmp_mask,
`endif
    output logic                       cmp_valid,
    output logic                       cmp_pass,
    output logic [CNT_WIDTH-1:0]       pass_cnt,
    output logic [CNT_WIDTH-1:0]       fail_cnt,
    output logic [CNT_WIDTH-1:0]       orphan_cnt,
    output logic [CNT_WIDTH-1:0]       ovf_cnt,
    output logic [$clog2(DEPTH):0]     pending,
    output logic                       fifo_full,
    output logic                       mismatch,
    output logic [CNT_WIDTH-1:0]       first_fail_idx,
    output logic [DATA_WIDTH-1:0]      first_fail_exp,
    output logic [DATA_WIDTH-1:0]      first_fail_act,
    output logic [1:0]                 state
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FAIL = 2'd2;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [AW-1:0]        PTR_ONE  = AW'(1);
    localparam logic [AW:0]          PEND_ONE = (AW+1)'(1);
    // DEPTH is a power of two, so "full" is just the top occupancy bit pattern
    localparam logic [AW:0]          FULL_LVL = {1'b1, {AW{1'b0}}};

    logic                  exp_d1;
    logic                  act_d1;
    logic                  exp_ev;
    logic                  act_ev;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  fifo_empty;
    logic                  do_pop;
    logic                  do_push;
    logic                  bypass;
    logic                  orphan;
    logic                  ovf;
    logic                  do_cmp;
    logic                  cmp_ok;
    logic                  cmp_fail;
    logic [DATA_WIDTH-1:0] cmp_exp;
    logic [DATA_WIDTH-1:0] mask_w;
    logic [CNT_WIDTH-1:0]  cmp_idx;

`ifdef RES_SB_MASK_EN
    assign mask_w = cmp_mask;
`else
    assign mask_w = '1;
`endif

    assign fifo_full = (pending == FULL_LVL);

    // Event decode and compare datapath. An actual event with an empty FIFO
    // but a same-cycle expected event compares straight against exp_data
    // instead of round-tripping through the FIFO.
    always_comb begin
        exp_ev     = (EDGE_MODE != 0) ? (exp_valid & ~exp_d1) : exp_valid;
        act_ev     = (EDGE_MODE != 0) ? (act_valid & ~act_d1) : act_valid;
        fifo_empty = (pending == '0);
        do_pop     = act_ev & ~fifo_empty;
        bypass     = act_ev & fifo_empty & exp_ev;
        orphan     = act_ev & fifo_empty & ~exp_ev;
        do_push    = exp_ev & ~bypass & (~fifo_full | do_pop);
        ovf        = exp_ev & fifo_full & ~do_pop;
        do_cmp     = do_pop | bypass;
        cmp_exp    = fifo_empty ? exp_data : mem[rd_ptr];
        cmp_ok     = (((cmp_exp ^ act_data) & mask_w) == '0);
        cmp_fail   = do_cmp & ~cmp_ok;
    end

    // Valid history for edge detection. Deliberately ignores clear so that a
    // valid held high across a clear does not look like a fresh rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_d1 <= 1'b0;
            act_d1 <= 1'b0;
        end else begin
            exp_d1 <= exp_valid;
            act_d1 <= act_valid;
        end
    end

    // FIFO storage needs no reset; occupancy and pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wr_ptr] <= exp_data;
        end
    end

    // Control, counters, flags, snapshot and state. clear discards any
    // events of the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            pending        <= '0;
            cmp_valid      <= 1'b0;
            cmp_pass       <= 1'b0;
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            orphan_cnt     <= '0;
            ovf_cnt        <= '0;
            mismatch       <= 1'b0;
            cmp_idx        <= '0;
            first_fail_idx <= '0;
            first_fail_exp <= '0;
            first_fail_act <= '0;
            state          <= ST_IDLE;
        end else if (clear) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            pending        <= '0;
            cmp_valid      <= 1'b0;
            cmp_pass       <= 1'b0;
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            orphan_cnt     <= '0;
            ovf_cnt        <= '0;
            mismatch       <= 1'b0;
            cmp_idx        <= '0;
            first_fail_idx <= '0;
            first_fail_exp <= '0;
            first_fail_act <= '0;
            state          <= ST_IDLE;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   pending <= pending + PEND_ONE;
                2'b01:   pending <= pending - PEND_ONE;
                default: pending <= pending;
            endcase

            cmp_valid <= do_cmp;
            cmp_pass  <= do_cmp & cmp_ok;

            if (do_cmp && cmp_ok && pass_cnt != CNT_MAX) begin
                pass_cnt <= pass_cnt + CNT_ONE;
            end
            if (cmp_fail && fail_cnt != CNT_MAX) begin
                fail_cnt <= fail_cnt + CNT_ONE;
            end
            if (orphan && orphan_cnt != CNT_MAX) begin
                orphan_cnt <= orphan_cnt + CNT_ONE;
            end
            if (ovf && ovf_cnt != CNT_MAX) begin
                ovf_cnt <= ovf_cnt + CNT_ONE;
            end
            if (do_cmp && cmp_idx != CNT_MAX) begin
                cmp_idx <= cmp_idx + CNT_ONE;
            end

            // fail_cnt still zero means this is the first fail since reset/clear
            if (cmp_fail && fail_cnt == '0) begin
                first_fail_idx <= cmp_idx;
                first_fail_exp <= cmp_exp;
                first_fail_act <= act_data;
            end

            if (cmp_fail || orphan) begin
                mismatch <= 1'b1;
            end

            if (cmp_fail || orphan) begin
                state <= ST_FAIL;
            end else if (state == ST_IDLE && (exp_ev || act_ev)) begin
                state <= ST_RUN;
            end
        end
    end

endmodule

// File: doc/res_scoreboard.md
# res_scoreboard

In-order expected-vs-actual response scoreboard. It captures two response streams, one expected and one actual, and buffers the expected entries in a DEPTH-entry FIFO. Each actual entry is compared against the oldest buffered expected entry, and the block keeps saturating pass/fail/orphan/overflow counters, a sticky mismatch flag and a snapshot of the first failure. It sits in the testbench beside the DUT and generalises the team's dual-stream end-of-sim comparison into a live, cycle-accurate checker with configurable width, depth and capture mode.

## Interface
- DATA_WIDTH, 256, width of both data streams (1..1024)
- DEPTH, 16, expected-FIFO entries; power of two, >= 2
- EDGE_MODE, 1, capture mode: 1 captures on the rising edge of valid; 0 captures every cycle valid is high
- CNT_WIDTH, 16, width of all counters and of first_fail_idx
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- clear  in  1  synchronous clear of FIFO, counters, flags and snapshot
- exp_valid  in  1  expected stream valid
- exp_data  in  DATA_WIDTH  expected stream data
- act_valid  in  1  actual stream valid
- act_data  in  DATA_WIDTH  actual stream data
- cmp_valid  out  1  one-cycle pulse: a comparison completed
- cmp_pass  out  1  result of that comparison; meaningful only while cmp_valid is high
- pass_cnt, fail_cnt, orphan_cnt, ovf_cnt  out  CNT_WIDTH each  saturating event counters
- pending  out  $clog2(DEPTH)+1  FIFO occupancy
- fifo_full  out  1  pending == DEPTH
- mismatch  out  1  sticky; set by any fail or orphan
- first_fail_idx  out  CNT_WIDTH  compare index (0-based) of the first fail
- first_fail_exp, first_fail_act  out  DATA_WIDTH each  data of the first fail
- state  out  2  0 IDLE, 1 RUN, 2 FAIL

## Operation
- Event detection:
  - EDGE_MODE=1: event = valid & ~valid_d1. The _d1 registers reset to 0, so valid high on the first cycle after reset is an event.
  - EDGE_MODE=0: event = valid.
- Expected event:
  - Pushes exp_data into the FIFO.
  - If the FIFO is full and no pop occurs in the same cycle, the data is dropped and ovf_cnt increments.
  - Full with a simultaneous pop: the push is accepted.
- Actual event, FIFO non-empty: pops the head and compares it with act_data.
- Actual event, FIFO empty, simultaneous expected event: the compare bypasses the FIFO and uses the incoming exp_data; nothing is pushed.
- Actual event, FIFO empty, no expected event: orphan. orphan_cnt increments, mismatch is set, and no compare is made (cmp_valid stays low).
- Compare index: an internal counter cmp_idx increments on every compare and saturates.
- On the first fail since reset/clear, latch first_fail_idx = cmp_idx, first_fail_exp and first_fail_act. Later fails leave the snapshot untouched.
- All counters saturate at 2^CNT_WIDTH-1.
- State machine (state output):
  - IDLE -> RUN on the first expected or actual event.
  - RUN -> FAIL on a fail or an orphan.
  - FAIL is terminal until rst or clear.
  - Overflow alone does not enter FAIL.
- clear: same effect as reset, applied synchronously. When clear coincides with events, clear wins and the events are discarded. The valid_d1 registers still update, so a held valid does not re-trigger in EDGE_MODE=1.

## Timing
- Reset value of every output is 0, and state is IDLE.
- An actual event in cycle N gives cmp_valid/cmp_pass in cycle N+1. Counters, mismatch, the snapshot and state also update in N+1.
- pending and fifo_full reflect push/pop one cycle after the event.
- Push and pop in the same cycle leave pending unchanged.
- Reset asserted mid-operation: all state clears immediately and asynchronously, and no cmp_valid pulse is emitted.
- No backpressure: both streams are always accepted.

## Configuration
- RES_SB_MASK_EN defined:
  - Adds the input port cmp_mask (DATA_WIDTH).
  - Compare is ((exp ^ act) & cmp_mask) == 0; a mask bit of 1 means that bit is compared.
  - The mask is sampled in the same cycle as the actual event.
  - The snapshot stores unmasked data.
- RES_SB_MASK_EN undefined: no cmp_mask port; every bit is compared.

## Test plan
- EDGE_MODE=1, DEPTH=4: push expected 0xA1, 0xA2 (each a one-cycle valid pulse), then actual 0xA1, 0xA2 -> two cmp_valid pulses with cmp_pass=1, pass_cnt=2, pending=0, state RUN.
- Expected 0x10, then actual 0x11 -> cmp_pass=0, fail_cnt=1, mismatch=1, first_fail_idx=0, first_fail_exp=0x10, first_fail_act=0x11, state FAIL. A second fail leaves the snapshot unchanged.
- DEPTH=4: push 5 expected entries without actuals -> fifo_full=1, ovf_cnt=1, pending=4. With the FIFO full, a simultaneous expected+actual event -> pending stays 4 and ovf_cnt stays 1.
- Actual event with the FIFO empty -> orphan_cnt=1, mismatch=1, no cmp_valid. Simultaneous expected 0x55 / actual 0x55 with the FIFO empty -> cmp_pass=1, pending=0.
- EDGE_MODE=1 with valid held high for 3 cycles -> 1 capture. EDGE_MODE=0 under the same stimulus -> 3 captures. Assert rst mid-stream -> all outputs 0, state IDLE.
- With RES_SB_MASK_EN: expected 0xFF00, actual 0xFF0F, cmp_mask 0xFFF0 -> pass. With cmp_mask 0xFFFF -> fail.
